// File: rtl/mul_div_32.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, with sign fix-up in a final cycle. The result appears 33 cycles after start.
module mul_div_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_raw_q, a_raw_d;
    logic [WIDTH-1:0]  opd_q, opd_d;
    logic [WIDTH-1:0]  upper_q, upper_d;
    logic [WIDTH-1:0]  lower_q, lower_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    msum;
    logic [WIDTH:0]    trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_raw_d    = a_raw_q;
        opd_d      = opd_q;
        upper_d    = upper_q;
        lower_d    = lower_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        // op[0] selects the signed variants for both multiply and divide
        a_neg = op[0] & op_a[WIDTH-1];
        b_neg = op[0] & op_b[WIDTH-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;

        // Multiply: {upper, lower} is the accumulator with the multiplier shifting out of lower
        msum  = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opd_q} : '0);
        // Divide: upper is the partial remainder, lower shifts dividend out and quotient in
        trial = {upper_q, lower_q[WIDTH-1]} - {1'b0, opd_q};

        prod     = {upper_q, lower_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lower_q : lower_q;
        rem_fix  = neg_rem_q ? -upper_q : upper_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StCalc;
                    cnt_d      = '0;
                    op_d       = op;
                    a_raw_d    = op_a;
                    opd_d      = op[1] ? b_mag : a_mag;
                    upper_d    = '0;
                    lower_d    = op[1] ? a_mag : b_mag;
                    neg_d      = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = op[1] & (op_b == '0);
                end
            end
            StCalc: begin
                if (op_q[1]) begin
                    if (!trial[WIDTH]) begin
                        upper_d = trial[WIDTH-1:0];
                        lower_d = {lower_q[WIDTH-2:0], 1'b1};
                    end else begin
                        upper_d = {upper_q[WIDTH-2:0], lower_q[WIDTH-1]};
                        lower_d = {lower_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    upper_d = msum[WIDTH:1];
                    lower_d = {msum[0], lower_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            a_raw_q    <= '0;
            opd_q      <= '0;
            upper_q    <= '0;
            lower_q    <= '0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_raw_q    <= a_raw_d;
            opd_q      <= opd_d;
            upper_q    <= upper_d;
            lower_q    <= lower_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
